// File: rtl/click_conditioner_pkg.sv
// Shared constants for the click front end: player count/index width (shared
// with the game core) and default conditioning parameters.
package click_conditioner_pkg;

    localparam int NUM_PLAYERS         = 4;
    localparam int PLAYER_W            = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 3;

    typedef logic [PLAYER_W-1:0] player_t;

    // Round-robin successor of a player index, wrapping at NUM_PLAYERS.
    function automatic player_t next_player(input player_t p);
        return (int'(p) == NUM_PLAYERS - 1) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/click_debounce.sv
// One click line: synchronizer chain, debounce counter and a rise flag that is
// high in the cycle whose edge moves the clean level from 0 to 1.
module click_debounce
    import click_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   clean_reg;
    logic                   sync;
    logic                   at_limit;

    assign sync     = sync_reg[SYNC_STAGES-1];
    assign at_limit = (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
    // Combinational so the pending bit can be set on the same edge clean rises.
    assign rise     = sync & ~clean_reg & at_limit;
    assign clean    = clean_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            clean_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
            if (sync == clean_reg) begin
                cnt_reg <= '0;
            end else if (at_limit) begin
                clean_reg <= sync;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/click_conditioner.sv
// Conditions the raw player click lines and serialises their rising edges onto
// a single valid/ready event port using round-robin arbitration.
module click_conditioner
    import click_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] raw_click,
    input  logic                   enable,
    output logic [NUM_PLAYERS-1:0] clean_click,
    output logic                   event_valid,
    output logic [PLAYER_W-1:0]    event_player,
    input  logic                   event_ready,
    output logic [NUM_PLAYERS-1:0] pending,
    output logic [NUM_PLAYERS-1:0] dropped
);

    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] pending_reg, pending_next;
    logic [NUM_PLAYERS-1:0] dropped_reg, dropped_next;
    logic [NUM_PLAYERS-1:0] set_mask, load_mask;
    logic                   event_valid_reg;
    player_t                event_player_reg;
    player_t                ptr_reg;
    player_t                pick_idx;
    logic                   pick_found;
    logic                   slot_free;
    logic                   load;

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_line
            click_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_click[gi]),
                .clean (clean_click[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    // First pending player at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            idx = (int'(ptr_reg) + k) % NUM_PLAYERS;
            if (!pick_found && pending_reg[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PLAYER_W'(idx);
            end
        end
    end

    assign slot_free = ~event_valid_reg | event_ready;
    assign load      = slot_free & enable & pick_found;
    assign load_mask = load ? (NUM_PLAYERS'(1) << pick_idx) : '0;
    assign set_mask  = rise & {NUM_PLAYERS{enable}};

    // A fresh rise wins over the load of the same bit and is not a drop.
    assign pending_next = enable ? (set_mask | (pending_reg & ~load_mask)) : '0;
    assign dropped_next = dropped_reg | (set_mask & pending_reg & ~load_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg      <= '0;
            dropped_reg      <= '0;
            event_valid_reg  <= 1'b0;
            event_player_reg <= '0;
            ptr_reg          <= '0;
        end else begin
            pending_reg <= pending_next;
            dropped_reg <= dropped_next;
            if (slot_free) begin
                event_valid_reg <= load;
                if (load) begin
                    event_player_reg <= pick_idx;
                    ptr_reg          <= next_player(pick_idx);
                end
            end
        end
    end

    assign event_valid  = event_valid_reg;
    assign event_player = event_player_reg;
    assign pending      = pending_reg;
    assign dropped      = dropped_reg;

endmodule

// File: tb/tb_click_conditioner.sv
// Self-checking bench for click_conditioner: directed scenarios plus random
// stimulus, all checked against a cycle-level behavioural model.
module tb_click_conditioner;

    localparam int NP = 4;
    localparam int SS = 2;
    localparam int DB = 4;

    logic          clk;
    logic          rst;
    logic [NP-1:0] raw_click;
    logic          enable;
    logic [NP-1:0] clean_click;
    logic          event_valid;
    logic [1:0]    event_player;
    logic          event_ready;
    logic [NP-1:0] pending;
    logic [NP-1:0] dropped;

    int n_vec;
    int n_fail;
    int cycle;

    click_conditioner dut (
        .clk          (clk),
        .rst          (rst),
        .raw_click    (raw_click),
        .enable       (enable),
        .clean_click  (clean_click),
        .event_valid  (event_valid),
        .event_player (event_player),
        .event_ready  (event_ready),
        .pending      (pending),
        .dropped      (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [NP-1:0] m_samples[$];
    logic [NP-1:0] m_clean;
    int            m_run[NP];
    logic [NP-1:0] m_pend;
    logic [NP-1:0] m_drop;
    logic          m_valid;
    int            m_player;
    int            m_ptr;
    int            accepted[$];

    task automatic model_reset();
        m_samples.delete();
        for (int s = 0; s < SS; s++) m_samples.push_back('0);
        m_clean  = '0;
        m_pend   = '0;
        m_drop   = '0;
        m_valid  = 1'b0;
        m_player = 0;
        m_ptr    = 0;
        for (int i = 0; i < NP; i++) m_run[i] = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [NP-1:0] sync_v;
        logic [NP-1:0] rise_v;
        logic [NP-1:0] new_clean;
        logic [NP-1:0] new_pend;
        int            loaded;
        int            p;
        bit            free;
        sync_v    = m_samples[0];
        new_clean = m_clean;
        rise_v    = '0;
        for (int i = 0; i < NP; i++) begin
            if (sync_v[i] != m_clean[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    new_clean[i] = sync_v[i];
                    rise_v[i]    = sync_v[i];
                    m_run[i]     = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        loaded = -1;
        free   = !m_valid || event_ready;
        if (free) begin
            p = -1;
            if (enable) begin
                for (int k = 0; k < NP; k++)
                    if (p < 0 && m_pend[(m_ptr + k) % NP]) p = (m_ptr + k) % NP;
            end
            if (p >= 0) begin
                m_valid  = 1'b1;
                m_player = p;
                m_ptr    = (p + 1) % NP;
                loaded   = p;
            end else begin
                m_valid = 1'b0;
            end
        end
        new_pend = m_pend;
        if (!enable) begin
            new_pend = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (rise_v[i]) begin
                    if (m_pend[i] && loaded != i) m_drop[i] = 1'b1;
                    new_pend[i] = 1'b1;
                end else if (loaded == i) begin
                    new_pend[i] = 1'b0;
                end
            end
        end
        m_samples.push_back(raw_click);
        void'(m_samples.pop_front());
        m_clean = new_clean;
        m_pend  = new_pend;
    endtask

    // One clock: record the handshake, step the model, compare after the edge.
    task automatic step();
        if (event_valid === 1'b1 && event_ready === 1'b1) begin
            accepted.push_back(int'(event_player));
            $display("txn: cycle %0d player %0d accepted", cycle, event_player);
        end
        model_edge();
        @(posedge clk);
        cycle++;
        #1;
        n_vec++;
        if (clean_click !== m_clean) begin
            n_fail++;
            $display("FAIL clean_click cycle %0d: got %b want %b", cycle, clean_click, m_clean);
        end
        n_vec++;
        if (pending !== m_pend) begin
            n_fail++;
            $display("FAIL pending cycle %0d: got %b want %b", cycle, pending, m_pend);
        end
        n_vec++;
        if (dropped !== m_drop) begin
            n_fail++;
            $display("FAIL dropped cycle %0d: got %b want %b", cycle, dropped, m_drop);
        end
        n_vec++;
        if (event_valid !== m_valid) begin
            n_fail++;
            $display("FAIL event_valid cycle %0d: got %b want %b", cycle, event_valid, m_valid);
        end
        n_vec++;
        if (int'(event_player) != m_player || $isunknown(event_player)) begin
            n_fail++;
            $display("FAIL event_player cycle %0d: got %0d want %0d", cycle, event_player, m_player);
        end
        @(negedge clk);
    endtask

    task automatic step_n(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        raw_click   = '0;
        enable      = 1'b1;
        event_ready = 1'b0;
        model_reset();
        accepted.delete();
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        cycle = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({clean_click, event_valid, event_player, pending, dropped} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b/%b/%0d/%b/%b want all zero",
                     clean_click, event_valid, event_player, pending, dropped);
        end
    endtask

    task automatic test_single_click();
        do_reset();
        event_ready  = 1'b1;
        raw_click[0] = 1'b1;
        step_n(5);
        n_vec++;
        if (clean_click !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_edge5_clean: got %b want 0000", clean_click);
        end
        step();
        n_vec++;
        if (clean_click !== 4'b0001 || pending !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_edge6: clean %b pending %b want 0001/0001", clean_click, pending);
        end
        step();
        n_vec++;
        if (event_valid !== 1'b1 || event_player !== 2'd0) begin
            n_fail++;
            $display("FAIL single_edge7: valid %b player %0d want 1/0", event_valid, event_player);
        end
        step();
        n_vec++;
        if (event_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edge8: valid %b want 0", event_valid);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        do_reset();
        event_ready  = 1'b1;
        seen         = 1'b0;
        raw_click[2] = 1'b1;
        step_n(3);
        raw_click[2] = 1'b0;
        for (int s = 0; s < 15; s++) begin
            step();
            seen = seen | (|clean_click) | (|pending) | event_valid;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: activity seen %b want 0", seen);
        end
    endtask

    task automatic test_all_four();
        logic held_ok;
        do_reset();
        raw_click = 4'hF;
        held_ok   = 1'b1;
        step_n(7);
        for (int s = 0; s < 3; s++) begin
            held_ok = held_ok & (event_valid === 1'b1) & (event_player === 2'd0);
            step();
        end
        n_vec++;
        if (held_ok !== 1'b1 || event_player !== 2'd0) begin
            n_fail++;
            $display("FAIL all_four_hold: player %0d valid %b want held 0/1", event_player, event_valid);
        end
        event_ready = 1'b1;
        step_n(4);
        n_vec++;
        if (accepted.size() != 4) begin
            n_fail++;
            $display("FAIL all_four_count: got %0d events want 4", accepted.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (accepted[k] != k) begin
                    n_fail++;
                    $display("FAIL all_four_order[%0d]: got %0d want %0d", k, accepted[k], k);
                end
            end
        end
        step_n(2);
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        event_ready  = 1'b1;
        raw_click[1] = 1'b1;
        step_n(10);
        raw_click = 4'b1001;
        step_n(12);
        n_vec++;
        if (accepted.size() != 3) begin
            n_fail++;
            $display("FAIL pointer_count: got %0d events want 3", accepted.size());
        end else begin
            n_vec++;
            if (accepted[1] != 3 || accepted[2] != 0) begin
                n_fail++;
                $display("FAIL pointer_order: got %0d,%0d want 3,0", accepted[1], accepted[2]);
            end
        end
    endtask

    task automatic test_dropped();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            raw_click[1] = 1'b1;
            step_n(10);
            raw_click[1] = 1'b0;
            step_n(10);
        end
        n_vec++;
        if (dropped !== 4'b0010 || pending !== 4'b0010 || event_player !== 2'd1) begin
            n_fail++;
            $display("FAIL dropped_set: dropped %b pending %b player %0d want 0010/0010/1",
                     dropped, pending, event_player);
        end
        event_ready = 1'b1;
        step_n(10);
        n_vec++;
        if (dropped !== 4'b0010) begin
            n_fail++;
            $display("FAIL dropped_sticky: got %b want 0010", dropped);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        raw_click = 4'b0001;
        step_n(10);
        raw_click = 4'b1011;
        step_n(10);
        n_vec++;
        if (event_valid !== 1'b1 || pending !== 4'b1010) begin
            n_fail++;
            $display("FAIL async_pre: valid %b pending %b want 1/1010", event_valid, pending);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({clean_click, event_valid, event_player, pending, dropped} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%b/%0d/%b/%b want all zero",
                     clean_click, event_valid, event_player, pending, dropped);
        end
        raw_click = '0;
        model_reset();
        accepted.delete();
        @(negedge clk);
        rst         = 1'b1;
        event_ready = 1'b1;
        step_n(20);
        n_vec++;
        if (accepted.size() != 0 || event_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_after: %0d events valid %b want 0/0", accepted.size(), event_valid);
        end
    endtask

    task automatic test_random();
        int hold[NP];
        do_reset();
        for (int i = 0; i < NP; i++) hold[i] = $urandom_range(1, 12);
        for (int s = 0; s < 1500; s++) begin
            for (int i = 0; i < NP; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    raw_click[i] = ~raw_click[i];
                    hold[i]      = $urandom_range(1, 12);
                end
            end
            event_ready = ($urandom_range(0, 3) != 0);
            enable      = ($urandom_range(0, 24) != 0);
            step();
        end
    endtask

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        cycle       = 0;
        rst         = 1'b0;
        raw_click   = '0;
        enable      = 1'b1;
        event_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_click();
        test_glitch();
        test_all_four();
        test_pointer_wrap();
        test_dropped();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/click_conditioner.md
Name: click_conditioner

Overview:
- Front-end stage directly upstream of the game core: turns the four raw, asynchronous player click lines into clean levels and single click events.
- Per player: synchronizes the line, debounces it, and detects the rising edge of the debounced level.
- Pending clicks are arbitrated round-robin and presented one at a time on a valid/ready event port.
- The debounced levels also drive the game core's 4-bit `click` input directly.

Parameters:
- NUM_PLAYERS, 4, number of click lines; player index width is $clog2(NUM_PLAYERS), 2 at default.
- SYNC_STAGES, 2, synchronizer flops per line; minimum 2.
- DEBOUNCE_CYCLES, 4, consecutive cycles of disagreement needed before the debounced level changes; minimum 1.
- CNT_W, 3, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock; every flop is rising-edge.
- rst  in  1  asynchronous active-low reset; 0 resets all state immediately, release is synchronous to clk.
- raw_click  in  NUM_PLAYERS  raw button levels, asynchronous to clk.
- enable  in  1  1 = record new clicks; 0 = ignore rises and flush pending clicks.
- clean_click  out  NUM_PLAYERS  debounced levels, feeds game.click.
- event_valid  out  1  a click event is being presented.
- event_player  out  $clog2(NUM_PLAYERS)  player index of the presented event.
- event_ready  in  1  consumer accepts the event in this cycle.
- pending  out  NUM_PLAYERS  per-player click recorded but not yet loaded to the event port.
- dropped  out  NUM_PLAYERS  sticky flag: a rise arrived while that player's pending bit was already set.

Behaviour:
- Reset (rst=0): all synchronizer flops, clean_click, debounce counters, pending, dropped, event_valid and event_player go to 0; round-robin pointer goes to 0.
- Synchronizer: raw_click[i] passes through SYNC_STAGES flops to give sync[i].
- Debounce, per line:
  - If sync[i]==clean_click[i], the counter clears to 0.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1, clean_click[i] takes sync[i] and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes clean_click.
- Rise detect: a 0->1 update of clean_click[i] with enable=1 sets pending[i] on the same edge.
  - If pending[i] is already 1 and is not being loaded this cycle, the rise is lost and dropped[i] is set (sticky until reset).
  - Falling edges generate nothing.
- Event slot: a single output register (event_valid, event_player). The slot is free when event_valid=0 or event_ready=1.
- Arbitration: when the slot is free and any pending bit is set, pick the first set bit searching from the pointer upward with wrap-around. Then:
  - load event_player and set event_valid=1 on the next edge;
  - clear that pending bit;
  - set pointer = chosen index + 1 (mod NUM_PLAYERS).
  - If the slot is free and no bit is pending, event_valid goes to 0.
- Handshake:
  - event_valid and event_player stay stable until the cycle with event_ready=1.
  - A back-to-back transfer in the following cycle is allowed.
  - event_ready while event_valid=0 is ignored.
- Simultaneous events: a new rise for player i in the same cycle its pending bit is being loaded leaves pending[i]=1 (set wins) and does not set dropped[i].
- enable=0:
  - pending clears on the next edge and rises are ignored;
  - an event already in the slot is held until accepted;
  - debouncing and clean_click keep running.
- Latency (defaults): raw rise first sampled at edge 1 gives clean_click and pending at edge 6 and event_valid at edge 7, i.e. SYNC_STAGES+DEBOUNCE_CYCLES+1 edges.
- Reset mid-operation: an in-flight event and all pending clicks are discarded, with no partial handshake afterward.

Decomposition:
- Shared package:
  - NUM_PLAYERS and the player index width, shared with the game core's output_player width;
  - the default SYNC_STAGES and DEBOUNCE_CYCLES values.
- One natural sub-module, click_debounce: a single-line synchronizer, debounce counter and rise pulse, instantiated NUM_PLAYERS times.
- The arbiter and event slot stay in click_conditioner.

Test Plan:
- Reset, then raw_click[0] held high from edge 1 with event_ready=1 → clean_click[0]=1 and pending=4'b0001 at edge 6; event_valid=1, event_player=0 at edge 7; event_valid=0 at edge 8.
- 3-cycle high glitch on raw_click[2], DEBOUNCE_CYCLES=4 → clean_click, pending and event_valid all stay 0.
- All four lines rise on the same edge with event_ready=0 for 10 cycles, then 1 → events delivered in order 0,1,2,3, one per cycle; event_player is held constant while ready=0.
- Pointer=2 after a player-1 event, then players 0 and 3 pending together → player 3 is delivered first, then player 0.
- Player 1 clicks twice (debounced) while ready=0 and the slot is occupied by player 1 → the second click sets pending[1]; a third click sets dropped[1]=1, which stays set until rst.
- rst asserted low while event_valid=1 and pending=4'b1010 → all outputs are 0 immediately (asynchronous); after release no event appears without a new click.
